// File: rtl/alarm_ring_controller.sv
`timescale 1ns/1ps
// alarm_ring_controller
//   Compares the running clock time against the programmed alarm time and runs
//   the IDLE/RING/SNOOZE state machine. It drives the ringing/snoozing status
//   outputs, a 1 Hz beep pattern, the remaining-snooze count and a one-cycle
//   auto-stop pulse. All durations are counted in TICK_1HZ pulses.
// Ports
//   CLK, RESET           clock, async active-high reset
//   TICK_1HZ             one-CLK pulse per second
//   CUR_SEC/MIN/HR       running time, binary
//   ALM_SEC/MIN/HR       programmed alarm time, binary
//   ALARM_EN             level; low disarms and silences
//   SNOOZE, STOP         one-CLK debounced button pulses
//   RINGING, SNOOZING    state decode, registered
//   BUZZER               beep drive while ringing, registered
//   SNOOZES_LEFT         snoozes remaining for the current alarm event
//   TIMEOUT              one-CLK pulse when ringing auto-stops
module alarm_ring_controller #(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TICK_1HZ,
  input  logic [7:0] CUR_SEC,
  input  logic [7:0] CUR_MIN,
  input  logic [7:0] CUR_HR,
  input  logic [7:0] ALM_SEC,
  input  logic [7:0] ALM_MIN,
  input  logic [7:0] ALM_HR,
  input  logic       ALARM_EN,
  input  logic       SNOOZE,
  input  logic       STOP,
  output logic       RINGING,
  output logic       SNOOZING,
  output logic       BUZZER,
  output logic [3:0] SNOOZES_LEFT,
  output logic       TIMEOUT
);

  localparam logic [7:0]  RING_LAST = 8'(RING_TIMEOUT_S - 1);
  localparam logic [15:0] SNZ_LAST  = 16'(SNOOZE_S - 1);
  localparam logic [3:0]  SNZ_MAX   = 4'(MAX_SNOOZES);

  typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_match_q;
  logic [7:0]  r_ring_cnt, w_ring_cnt_nxt;
  logic [15:0] r_snz_cnt, w_snz_cnt_nxt;
  logic        r_beep, w_beep_nxt;
  logic [3:0]  r_left, w_left_nxt;
  logic        w_timeout_nxt;
  logic        w_match, w_rise;

  assign w_match = (CUR_SEC == ALM_SEC) && (CUR_MIN == ALM_MIN) && (CUR_HR == ALM_HR);
  // Only the first cycle of a match arms the alarm; holding the matching
  // second after STOP must not re-trigger.
  assign w_rise  = w_match && !r_match_q;

  assign SNOOZES_LEFT = r_left;

  always_comb begin
    w_state_nxt    = r_state;
    w_ring_cnt_nxt = r_ring_cnt;
    w_snz_cnt_nxt  = r_snz_cnt;
    w_beep_nxt     = r_beep;
    w_left_nxt     = r_left;
    w_timeout_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ALARM_EN && w_rise) begin
          w_state_nxt    = S_RING;
          w_ring_cnt_nxt = '0;
          w_beep_nxt     = 1'b1;
          w_left_nxt     = SNZ_MAX;
        end
      end
      S_RING: begin
        if (!ALARM_EN || STOP) begin
          w_state_nxt = S_IDLE;
        end else if (SNOOZE && r_left != 4'd0) begin
          w_state_nxt   = S_SNOOZE;
          w_snz_cnt_nxt = '0;
          w_left_nxt    = r_left - 4'd1;
        end else if (TICK_1HZ) begin
          // An exhausted SNOOZE press falls through so the tick still counts.
          w_beep_nxt     = !r_beep;
          w_ring_cnt_nxt = r_ring_cnt + 8'd1;
          if (r_ring_cnt == RING_LAST) begin
            w_state_nxt   = S_IDLE;
            w_timeout_nxt = 1'b1;
          end
        end
      end
      S_SNOOZE: begin
        if (!ALARM_EN || STOP) begin
          w_state_nxt = S_IDLE;
        end else if (TICK_1HZ) begin
          w_snz_cnt_nxt = r_snz_cnt + 16'd1;
          if (r_snz_cnt == SNZ_LAST) begin
            w_state_nxt    = S_RING;
            w_ring_cnt_nxt = '0;
            w_beep_nxt     = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_match_q  <= 1'b0;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
      r_beep     <= 1'b0;
      r_left     <= SNZ_MAX;
      RINGING    <= 1'b0;
      SNOOZING   <= 1'b0;
      BUZZER     <= 1'b0;
      TIMEOUT    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_match_q  <= w_match;
      r_ring_cnt <= w_ring_cnt_nxt;
      r_snz_cnt  <= w_snz_cnt_nxt;
      r_beep     <= w_beep_nxt;
      r_left     <= w_left_nxt;
      // Status outputs are registered copies of the next-state decode so they
      // line up exactly with r_state.
      RINGING    <= (w_state_nxt == S_RING);
      SNOOZING   <= (w_state_nxt == S_SNOOZE);
      BUZZER     <= (w_state_nxt == S_RING) && w_beep_nxt;
      TIMEOUT    <= w_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_alarm_ring_controller.sv
`timescale 1ns/1ps
module tb_alarm_ring_controller;
  localparam int RT = 60;
  localparam int ST = 300;
  localparam int MS = 3;

  logic CLK = 0, RESET = 1, TICK_1HZ = 0, ALARM_EN = 0, SNOOZE = 0, STOP = 0;
  logic [7:0] CUR_SEC = 0, CUR_MIN = 0, CUR_HR = 0;
  logic [7:0] ALM_SEC = 0, ALM_MIN = 0, ALM_HR = 0;
  logic RINGING, SNOOZING, BUZZER, TIMEOUT;
  logic [3:0] SNOOZES_LEFT;

  alarm_ring_controller #(.RING_TIMEOUT_S(RT), .SNOOZE_S(ST), .MAX_SNOOZES(MS)) dut (
    .CLK(CLK), .RESET(RESET), .TICK_1HZ(TICK_1HZ),
    .CUR_SEC(CUR_SEC), .CUR_MIN(CUR_MIN), .CUR_HR(CUR_HR),
    .ALM_SEC(ALM_SEC), .ALM_MIN(ALM_MIN), .ALM_HR(ALM_HR),
    .ALARM_EN(ALARM_EN), .SNOOZE(SNOOZE), .STOP(STOP),
    .RINGING(RINGING), .SNOOZING(SNOOZING), .BUZZER(BUZZER),
    .SNOOZES_LEFT(SNOOZES_LEFT), .TIMEOUT(TIMEOUT));

  always #5 CLK = ~CLK;

  int n_tests = 0, n_fail = 0;

  // Behavioural model: mode 0=idle 1=ringing 2=snoozing; elapsed-tick counters.
  int m_mode = 0, m_ring_ticks = 0, m_snz_ticks = 0, m_left = MS;
  bit m_prev_match = 0, m_to = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_ring_ticks = 0; m_snz_ticks = 0; m_left = MS;
    m_prev_match = 0; m_to = 0;
  endfunction

  function automatic void model_step(bit tick, bit snz, bit stp);
    bit match, first;
    match = (CUR_SEC == ALM_SEC) && (CUR_MIN == ALM_MIN) && (CUR_HR == ALM_HR);
    first = match && !m_prev_match;
    m_prev_match = match;
    m_to = 0;
    if (m_mode == 0) begin
      if (ALARM_EN && first) begin m_mode = 1; m_ring_ticks = 0; m_left = MS; end
    end else if (!ALARM_EN || stp) begin
      m_mode = 0;
    end else if (m_mode == 1) begin
      if (snz && m_left > 0) begin m_mode = 2; m_snz_ticks = 0; m_left--; end
      else if (tick) begin
        m_ring_ticks++;
        if (m_ring_ticks == RT) begin m_mode = 0; m_to = 1; end
      end
    end else if (tick) begin
      m_snz_ticks++;
      if (m_snz_ticks == ST) begin m_mode = 1; m_ring_ticks = 0; end
    end
  endfunction

  task automatic compare_all();
    check("RINGING", RINGING, m_mode == 1);
    check("SNOOZING", SNOOZING, m_mode == 2);
    check("BUZZER", BUZZER, (m_mode == 1) && (m_ring_ticks % 2 == 0));
    check("SNOOZES_LEFT", SNOOZES_LEFT, m_left);
    check("TIMEOUT", TIMEOUT, m_to);
  endtask

  // Drive one cycle of inputs, clock it, advance the model, compare.
  task automatic step(input bit tick, input bit snz, input bit stp);
    TICK_1HZ = tick; SNOOZE = snz; STOP = stp;
    @(posedge CLK);
    model_step(tick, snz, stp);
    #1;
    compare_all();
  endtask

  task automatic adv_time();
    if (CUR_SEC == 59) begin
      CUR_SEC = 0;
      if (CUR_MIN == 59) begin CUR_MIN = 0; CUR_HR = (CUR_HR == 23) ? 8'd0 : CUR_HR + 8'd1; end
      else CUR_MIN = CUR_MIN + 8'd1;
    end else CUR_SEC = CUR_SEC + 8'd1;
  endtask

  // Clock time advances together with the tick pulse, then one quiet cycle.
  task automatic tick_cycle();
    adv_time();
    step(1, 0, 0);
    step(0, 0, 0);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    CUR_HR = 8'(h); CUR_MIN = 8'(m); CUR_SEC = 8'(s);
  endtask

  // Bring time to one second before 07:30:00 and tick into the alarm.
  task automatic trigger();
    set_time(7, 29, 59);
    step(0, 0, 0);
    adv_time();
    step(1, 0, 0);
  endtask

  initial begin
    ALM_HR = 7; ALM_MIN = 30; ALM_SEC = 0;
    set_time(7, 29, 58);
    repeat (3) @(posedge CLK);
    #1;
    model_reset();
    check("reset_ringing", RINGING, 0);
    check("reset_buzzer", BUZZER, 0);
    check("reset_left", SNOOZES_LEFT, 3);
    check("reset_timeout", TIMEOUT, 0);
    RESET = 0;
    ALARM_EN = 1;

    // Basic trigger and beep pattern
    tick_cycle();
    check("pre_match_idle", RINGING, 0);
    adv_time();
    step(1, 0, 0);
    check("trig_ringing", RINGING, 1);
    check("trig_buzzer", BUZZER, 1);
    check("trig_left", SNOOZES_LEFT, 3);
    tick_cycle();
    check("beep_off", BUZZER, 0);
    tick_cycle();
    check("beep_on", BUZZER, 1);

    // Auto timeout: 58 more ticks -> 60th tick raises TIMEOUT
    repeat (57) tick_cycle();
    check("before_timeout", RINGING, 1);
    adv_time();
    step(1, 0, 0);
    check("timeout_pulse", TIMEOUT, 1);
    check("timeout_idle", RINGING, 0);
    check("timeout_buzzer", BUZZER, 0);
    step(0, 0, 0);
    check("timeout_one_clk", TIMEOUT, 0);

    // Snooze three times, fourth press ignored
    trigger();
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0);
      check("snoozing", SNOOZING, 1);
      check("snooze_left", SNOOZES_LEFT, 2 - k);
      repeat (ST - 1) tick_cycle();
      check("still_snoozing", SNOOZING, 1);
      adv_time();
      step(1, 0, 0);
      check("rering", RINGING, 1);
      check("rering_buzzer", BUZZER, 1);
    end
    step(0, 1, 0);
    check("snooze_exhausted_ring", RINGING, 1);
    check("snooze_exhausted_left", SNOOZES_LEFT, 0);
    step(0, 0, 1);
    check("stop_idle", RINGING, 0);
    check("left_held_idle", SNOOZES_LEFT, 0);

    // STOP+SNOOZE together, time held at the alarm second
    trigger();
    step(0, 1, 1);
    check("stop_wins", SNOOZING, 0);
    check("stop_wins_ring", RINGING, 0);
    repeat (5) step(0, 0, 0);
    check("no_retrigger", RINGING, 0);

    // ALARM_EN low during snooze
    trigger();
    step(0, 1, 0);
    ALARM_EN = 0;
    step(0, 0, 0);
    check("en_off_snooze", SNOOZING, 0);
    ALARM_EN = 1;
    step(0, 0, 0);

    // Async reset mid-ring
    trigger();
    tick_cycle();
    step(0, 1, 0);
    set_time(7, 29, 59);
    step(0, 0, 0);
    adv_time();
    step(1, 0, 0);
    // ringing again? no: snoozing ignores match, so stop and retrigger
    step(0, 0, 1);
    trigger();
    check("pre_reset_ring", RINGING, 1);
    #2 RESET = 1;
    #1;
    model_reset();
    check("async_rst_ring", RINGING, 0);
    check("async_rst_buzzer", BUZZER, 0);
    check("async_rst_left", SNOOZES_LEFT, 3);
    @(posedge CLK);
    #1 RESET = 0;
    step(0, 0, 0);

    // Enabled mid-second: no rising match seen while armed
    set_time(7, 29, 59);
    step(0, 0, 0);
    ALARM_EN = 0;
    adv_time();
    step(1, 0, 0);
    step(0, 0, 0);
    ALARM_EN = 1;
    repeat (4) step(0, 0, 0);
    check("late_enable_no_ring", RINGING, 0);

    // Randomized phase
    for (int i = 0; i < 6000; i++) begin
      bit t, sz, sp;
      if (i % 700 == 0) begin
        ALM_HR = 8'($urandom_range(0, 23));
        ALM_MIN = 8'($urandom_range(0, 59));
        ALM_SEC = 8'($urandom_range(0, 59));
        CUR_HR = ALM_HR; CUR_MIN = ALM_MIN;
        CUR_SEC = (ALM_SEC == 0) ? 8'd59 : ALM_SEC - 8'd1;
        if (ALM_SEC == 0) CUR_MIN = (ALM_MIN == 0) ? 8'd59 : ALM_MIN - 8'd1;
        if (ALM_SEC == 0 && ALM_MIN == 0) CUR_HR = (ALM_HR == 0) ? 8'd23 : ALM_HR - 8'd1;
      end
      ALARM_EN = ($urandom_range(0, 199) != 0);
      t  = ($urandom_range(0, 2) == 0);
      sz = ($urandom_range(0, 40) == 0);
      sp = ($urandom_range(0, 150) == 0);
      if (t) adv_time();
      step(t, sz, sp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
